// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// IFETCH_MISALIGN_TRAP_EN adds the HALT state used by the misalign trap.
package ifetch_pkg;

`ifdef IFETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } ifetch_state_e;
`else
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1
  } ifetch_state_e;
`endif

  localparam logic [1:0] JUMP_NONE = 2'b00;
  localparam logic [1:0] JUMP_J    = 2'b01;
  localparam logic [1:0] JUMP_JR   = 2'b10;

  localparam int OP_W      = 6;
  localparam int OP_LSB    = 26;
  localparam int OP_MSB    = OP_LSB + OP_W - 1;
  localparam int FUNCT_W   = 6;
  localparam int FUNCT_LSB = 0;
  localparam int FUNCT_MSB = FUNCT_LSB + FUNCT_W - 1;
  localparam int IMM_W     = 16;
  localparam int JIDX_W    = 26;

endpackage

// File: rtl/next_pc.sv
// Combinational next-PC select: jr > j/jal > taken branch > pc+4.
// Also flags a next PC whose low two bits are non-zero.
module next_pc
  import ifetch_pkg::*;
#(
  parameter int n = 32
) (
  input  logic [n-1:0] pc_plus4_i,
  input  logic [31:0]  instr_i,
  input  logic         pcsrc_i,
  input  logic [1:0]   jump_i,
  input  logic [n-1:0] jr_target_i,
  output logic [n-1:0] npc_o,
  output logic         misalign_o
);

  logic [n-1:0] br_off;
  logic [n-1:0] br_tgt;
  logic [n-1:0] j_tgt;
  logic         sel_jr;
  logic         sel_j;
  logic         sel_br;

  assign br_off = {{(n-IMM_W-2){instr_i[IMM_W-1]}},
                   instr_i[IMM_W-1:0], 2'b00};
  assign br_tgt = pc_plus4_i + br_off;
  assign j_tgt  = {pc_plus4_i[n-1:JIDX_W+2],
                   instr_i[JIDX_W-1:0], 2'b00};

  // Priority folded into one-hot selects
  assign sel_jr = (jump_i == JUMP_JR);
  assign sel_j  = (jump_i == JUMP_J);
  assign sel_br = pcsrc_i && !sel_jr && !sel_j;

  always_comb begin
    npc_o = pc_plus4_i;
    unique case (1'b1)
      sel_jr:  npc_o = jr_target_i;
      sel_j:   npc_o = j_tgt;
      sel_br:  npc_o = br_tgt;
      default: npc_o = pc_plus4_i;
    endcase
  end

  assign misalign_o = |npc_o[1:0];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, imem req/ack, instruction register, next PC.
// IFETCH_MISALIGN_TRAP_EN traps misaligned next PCs into HALT.
module instr_fetch
  import ifetch_pkg::*;
#(
  parameter int           n        = 32,
  parameter logic [n-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         imem_req,
  output logic [n-1:0] imem_addr,
  input  logic [31:0]  imem_rdata,
  input  logic         imem_ack,
  input  logic         pcsrc,
  input  logic [1:0]   jump,
  input  logic [n-1:0] jr_target,
  input  logic         retire,
  output logic [31:0]  instr,
  output logic [5:0]   op,
  output logic [5:0]   funct,
  output logic         instr_valid,
  output logic [n-1:0] pc,
  output logic [n-1:0] pc_plus4,
  output logic         misalign
);

  ifetch_state_e state_q, state_d;
  logic [n-1:0]  pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic          req_q, req_d;
  logic [n-1:0]  pc4;
  logic [n-1:0]  npc_raw;
  logic          npc_mis;
  logic [n-1:0]  npc;

  assign pc4 = pc_q + {{(n-3){1'b0}}, 3'd4};

  next_pc #(
    .n (n)
  ) u_next_pc (
    .pc_plus4_i  (pc4),
    .instr_i     (instr_q),
    .pcsrc_i     (pcsrc),
    .jump_i      (jump),
    .jr_target_i (jr_target),
    .npc_o       (npc_raw),
    .misalign_o  (npc_mis)
  );

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic mis_q, mis_d;

  assign npc      = npc_raw;
  assign misalign = mis_q;
`else
  // No trap: a misaligned target is silently word-aligned
  assign npc      = npc_mis ? {npc_raw[n-1:2], 2'b00} : npc_raw;
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    req_d   = req_q;
`ifdef IFETCH_MISALIGN_TRAP_EN
    mis_d   = mis_q;
`endif
    unique case (state_q)
      FETCH: begin
        req_d = 1'b1;
        if (req_q && imem_ack) begin
          instr_d = imem_rdata;
          req_d   = 1'b0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        req_d = 1'b0;
        if (retire) begin
`ifdef IFETCH_MISALIGN_TRAP_EN
          if (npc_mis) begin
            mis_d   = 1'b1;
            state_d = HALT;
          end else begin
            pc_d    = npc;
            req_d   = 1'b1;
            state_d = FETCH;
          end
`else
          pc_d    = npc;
          req_d   = 1'b1;
          state_d = FETCH;
`endif
        end
      end
`ifdef IFETCH_MISALIGN_TRAP_EN
      HALT: begin
        req_d = 1'b0;
      end
`endif
      default: begin
        req_d   = 1'b0;
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      req_q   <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      req_q   <= req_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign op          = instr_q[OP_MSB:OP_LSB];
  assign funct       = instr_q[FUNCT_MSB:FUNCT_LSB];
  assign instr_valid = (state_q == HOLD);
  assign pc          = pc_q;
  assign pc_plus4    = pc4;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch with a behavioural next-PC model.
// Expectations follow IFETCH_MISALIGN_TRAP_EN when it is defined.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_ack = 1'b0;
  logic        pcsrc = 1'b0;
  logic [1:0]  jump = 2'b00;
  logic [31:0] jr_target = '0;
  logic        retire = 1'b0;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  instr_fetch #(
    .n        (32),
    .RESET_PC (RST_PC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ack    (imem_ack),
    .pcsrc       (pcsrc),
    .jump        (jump),
    .jr_target   (jr_target),
    .retire      (retire),
    .instr       (instr),
    .op          (op),
    .funct       (funct),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .misalign    (misalign)
  );

  // Reference next PC from the architectural rules
  function automatic logic [31:0] model_next(
    input logic [31:0] cur, input logic [31:0] ins,
    input logic ps, input logic [1:0] jp, input logic [31:0] jt);
    logic [31:0] p4;
    logic [31:0] r;
    logic [15:0] imm;
    int          off;
    p4  = cur + 32'd4;
    imm = ins[15:0];
    off = int'($signed(imm));
    if (jp == 2'b10)      r = jt;
    else if (jp == 2'b01) r = (p4 & 32'hF000_0000) + (ins & 32'h03FF_FFFF) * 4;
    else if (ps)          r = p4 + 32'(off * 4);
    else                  r = p4;
`ifndef IFETCH_MISALIGN_TRAP_EN
    r = r & 32'hFFFF_FFFC;
`endif
    return r;
  endfunction

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_fetch(input logic [31:0] w, input int dly, output bit ok);
    wait_req(ok);
    if (!ok) return;
    repeat (dly) @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = w;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
  endtask

  task automatic do_retire(input logic ps, input logic [1:0] jp,
                           input logic [31:0] jt);
    pcsrc     = ps;
    jump      = jp;
    jr_target = jt;
    retire    = 1'b1;
    @(negedge clk);
    retire    = 1'b0;
    pcsrc     = 1'($urandom);
    jump      = 2'($urandom);
    jr_target = $urandom;
  endtask

  task automatic go_to(input logic [31:0] a);
    bit ok;
    do_fetch(32'h0000_0000, 0, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL goto_req: no imem_req within bound, required 1");
    end
    do_retire(1'b0, 2'b10, a);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    imem_ack = 1'b0;
    retire   = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    total += 5;
    if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
    if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    if (pc !== RST_PC) begin bad++; $display("FAIL rst_pc: got %h want %h", pc, RST_PC); end
    if (instr !== 32'h0) begin bad++; $display("FAIL rst_instr: got %h want 0", instr); end
    if (misalign !== 1'b0) begin bad++; $display("FAIL rst_mis: got %b want 0", misalign); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total += 2;
    if (imem_req !== 1'b1) begin bad++; $display("FAIL first_req: got %b want 1", imem_req); end
    if (imem_addr !== 32'h0) begin bad++; $display("FAIL first_addr: got %h want 0", imem_addr); end
    imem_ack   = 1'b1;
    imem_rdata = 32'h2008_0005;
    @(negedge clk);
    imem_ack   = 1'b0;
    total += 5;
    if (instr_valid !== 1'b1) begin bad++; $display("FAIL zw_valid: got %b want 1", instr_valid); end
    if (op !== 6'b001000) begin bad++; $display("FAIL zw_op: got %b want 001000", op); end
    if (funct !== 6'b000101) begin bad++; $display("FAIL zw_funct: got %b want 000101", funct); end
    if (pc !== 32'h0) begin bad++; $display("FAIL zw_pc: got %h want 0", pc); end
    if (imem_req !== 1'b0) begin bad++; $display("FAIL zw_req: got %b want 0", imem_req); end
  endtask

  task automatic test_seq();
    do_retire(1'b0, 2'b00, $urandom);
    total += 4;
    if (pc !== 32'h4) begin bad++; $display("FAIL seq_pc: got %h want 4", pc); end
    if (instr_valid !== 1'b0) begin bad++; $display("FAIL seq_valid: got %b want 0", instr_valid); end
    if (imem_req !== 1'b1) begin bad++; $display("FAIL seq_req: got %b want 1", imem_req); end
    if (imem_addr !== 32'h4) begin bad++; $display("FAIL seq_addr: got %h want 4", imem_addr); end
  endtask

  task automatic test_branch();
    bit ok;
    go_to(32'h0000_0008);
    do_fetch(32'h1000_FFFE, 1, ok);
    total++;
    if (pc !== 32'h8) begin bad++; $display("FAIL br_at: got %h want 8", pc); end
    do_retire(1'b1, 2'b00, $urandom);
    total++;
    if (pc !== 32'h4) begin bad++; $display("FAIL br_pc: got %h want 4", pc); end
  endtask

  task automatic test_jump();
    bit ok;
    go_to(32'h0040_0000);
    do_fetch(32'h0800_0010, 0, ok);
    do_retire(1'b1, 2'b01, $urandom);
    total++;
    if (pc !== 32'h0000_0040) begin bad++; $display("FAIL j_pc: got %h want 00000040", pc); end
  endtask

  task automatic test_wrap();
    bit ok;
    go_to(32'hFFFF_FFFC);
    do_fetch(32'h0000_0020, 0, ok);
    total++;
    if (pc_plus4 !== 32'h0) begin bad++; $display("FAIL wrap_p4: got %h want 0", pc_plus4); end
    do_retire(1'b0, 2'b11, $urandom);
    total++;
    if (pc !== 32'h0) begin bad++; $display("FAIL wrap_pc: got %h want 0", pc); end
  endtask

  task automatic test_ack_delay();
    bit ok;
    logic [31:0] a0, p0;
    wait_req(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL dly_req: no imem_req within bound, required 1"); end
    a0 = imem_addr;
    p0 = pc;
    for (int i = 0; i < 3; i++) begin
      retire = (i == 1);
      @(negedge clk);
      retire = 1'b0;
      total += 4;
      if (imem_req !== 1'b1) begin bad++; $display("FAIL dly_req%0d: got %b want 1", i, imem_req); end
      if (imem_addr !== a0) begin bad++; $display("FAIL dly_addr%0d: got %h want %h", i, imem_addr, a0); end
      if (instr_valid !== 1'b0) begin bad++; $display("FAIL dly_valid%0d: got %b want 0", i, instr_valid); end
      if (pc !== p0) begin bad++; $display("FAIL dly_pc%0d: got %h want %h", i, pc, p0); end
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'h0123_4567;
    @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack   = 1'b0;
    total += 2;
    if (instr_valid !== 1'b1) begin bad++; $display("FAIL dly_hold: got %b want 1", instr_valid); end
    if (instr !== 32'h0123_4567) begin bad++; $display("FAIL hold_ack_ign: got %h want 01234567", instr); end
    rst_n = 1'b0;
    #1;
    total += 4;
    if (instr_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", instr_valid); end
    if (imem_req !== 1'b0) begin bad++; $display("FAIL mid_req: got %b want 0", imem_req); end
    if (pc !== RST_PC) begin bad++; $display("FAIL mid_pc: got %h want %h", pc, RST_PC); end
    if (instr !== 32'h0) begin bad++; $display("FAIL mid_instr: got %h want 0", instr); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total += 2;
    if (imem_req !== 1'b1) begin bad++; $display("FAIL mid_rereq: got %b want 1", imem_req); end
    if (imem_addr !== RST_PC) begin bad++; $display("FAIL mid_addr: got %h want %h", imem_addr, RST_PC); end
  endtask

  task automatic test_jr();
    bit ok;
    do_fetch(32'h0000_0008, 0, ok);
    do_retire(1'b0, 2'b10, 32'h0000_0102);
`ifdef IFETCH_MISALIGN_TRAP_EN
    repeat (3) @(negedge clk);
    total += 4;
    if (misalign !== 1'b1) begin bad++; $display("FAIL jr_mis: got %b want 1", misalign); end
    if (imem_req !== 1'b0) begin bad++; $display("FAIL jr_req: got %b want 0", imem_req); end
    if (instr_valid !== 1'b0) begin bad++; $display("FAIL jr_valid: got %b want 0", instr_valid); end
    if (pc !== RST_PC) begin bad++; $display("FAIL jr_pc: got %h want %h", pc, RST_PC); end
`else
    total += 3;
    if (pc !== 32'h0000_0100) begin bad++; $display("FAIL jr_pc: got %h want 00000100", pc); end
    if (misalign !== 1'b0) begin bad++; $display("FAIL jr_mis: got %b want 0", misalign); end
    if (imem_req !== 1'b1) begin bad++; $display("FAIL jr_req: got %b want 1", imem_req); end
`endif
  endtask

  task automatic test_random();
    bit ok;
    logic [31:0] pc_m, w, jt, exp;
    logic        ps;
    logic [1:0]  jp;
    apply_reset();
    pc_m = RST_PC;
    for (int k = 0; k < 40; k++) begin
      w = $urandom;
      do_fetch(w, int'($urandom_range(0, 3)), ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL rnd_req%0d: no imem_req within bound, required 1", k);
        break;
      end
      if ($urandom_range(0, 2) == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = ~w;
        @(negedge clk);
        imem_ack   = 1'b0;
      end
      total += 4;
      if (instr !== w) begin bad++; $display("FAIL rnd_instr%0d: got %h want %h", k, instr, w); end
      if ({op, funct} !== {w[31:26], w[5:0]}) begin bad++; $display("FAIL rnd_fields%0d: got %b/%b want %b/%b", k, op, funct, w[31:26], w[5:0]); end
      if (pc !== pc_m) begin bad++; $display("FAIL rnd_pc%0d: got %h want %h", k, pc, pc_m); end
      if (pc_plus4 !== pc_m + 32'd4) begin bad++; $display("FAIL rnd_p4%0d: got %h want %h", k, pc_plus4, pc_m + 32'd4); end
      ps = 1'($urandom);
      jp = 2'($urandom);
      jt = $urandom;
`ifdef IFETCH_MISALIGN_TRAP_EN
      jt = jt & 32'hFFFF_FFFC;
`endif
      exp = model_next(pc_m, w, ps, jp, jt);
      do_retire(ps, jp, jt);
      total += 3;
      if (pc !== exp) begin bad++; $display("FAIL rnd_npc%0d: got %h want %h", k, pc, exp); end
      if (instr_valid !== 1'b0) begin bad++; $display("FAIL rnd_valid%0d: got %b want 0", k, instr_valid); end
      if (imem_addr !== exp) begin bad++; $display("FAIL rnd_addr%0d: got %h want %h", k, imem_addr, exp); end
      pc_m = exp;
    end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_branch();
    test_jump();
    test_wrap();
    test_ack_delay();
    test_jr();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
